uart_tx: RTL
============

// Module: uart_tx
// PURPOSE
//  Serial transmitter feeding the uart_rx receiver over a single wire (txd -> rxd).
//  Accepts bytes over a valid/ready handshake and emits 11-bit frames:
//  start(0), 8 data bits LSB-first, parity, stop(1).
//  With CLKS_PER_BIT=1 the timing matches uart_rx exactly:
//  one bit per clk, stop slot doubles as the receiver's end/re-arm slot.
// PARAMETERS
//  CLKS_PER_BIT  1  clk cycles per serial bit; legal range 1..65535
//  PARITY_ODD    0  0: parity = ^data (even, as uart_rx checks); 1: parity = ~^data
// PORTS
//  clk       in   1  clock
//  rst       in   1  reset, asynchronous, active-low
//  tx_data   in   8  byte to send; sampled only on the handshake cycle
//  tx_valid  in   1  tx_data is valid
//  tx_ready  out  1  transmitter can accept a byte this cycle
//  txd       out  1  serial line; idles high
//  tx_busy   out  1  a frame is in progress (state != IDLE)
//  tx_done   out  1  one-cycle pulse on the last clk of the stop bit
// BEHAVIOUR
//  - Reset (rst=0): state=IDLE, txd=1, tx_busy=0, tx_done=0, counters=0, shift reg=0.
//    Takes effect immediately, including mid-frame: line returns high, byte is lost.
//  - FSM, one-hot: IDLE, START, DATA, PARITY, STOP. Each non-IDLE state lasts
//    CLKS_PER_BIT clks, timed by baud counter bcnt (0..CLKS_PER_BIT-1).
//  - Handshake: a transfer occurs when tx_valid && tx_ready at a clk edge.
//    tx_ready = IDLE || (STOP && last clk of bit). It is combinational from state/bcnt
//    and never depends on tx_valid.
//  - Transfer at edge k: latch tx_data, compute parity, go to START.
//    txd is registered, so it is 0 from cycle k+1. Latency is 1 clk.
//  - DATA: shift the latched byte out LSB first. Bit counter 0..7 advances on each
//    last-clk of a bit; leave DATA after bit 7.
//  - PARITY: txd = latched parity. STOP: txd = 1.
//  - End of STOP:
//    - transfer pending -> START, giving back-to-back frames with no idle gap
//      (11*CLKS_PER_BIT clks per frame);
//    - no transfer -> IDLE.
//    tx_done pulses in that last STOP clk regardless of the next state.
//  - tx_valid held with tx_ready=0 has no effect. tx_data changes after the
//    handshake are ignored.
//  - The bit and baud counters reset to 0 on every state change. There is no
//    wrap-around beyond the ranges above.
//  - Simultaneous reset assertion and handshake: reset wins and no frame is sent.
// STRUCTURE
//  - uart_defs.vh (shared with uart_rx): one-hot state encodings and position
//    indices, DATA_BITS=8, FRAME_BITS=11.
//  - Sub-module uart_baud_tick: counter producing a bit_end pulse every CLKS_PER_BIT
//    clks while enabled; cleared when disabled.
//  - Top level holds the FSM, shift register, parity register and the txd register.
// TESTING
//  1. CLKS_PER_BIT=1, send 0xA5 after reset.
//     -> txd from cycle k+1 = 0,1,0,1,0,0,1,0,1,0,1; tx_done in the 11th cycle; then txd=1.
//  2. Back-to-back: 0x01, then 0xFF presented during the final STOP clk.
//     -> parity bits 1 then 0; second start bit directly follows the first stop;
//        22 busy cycles total.
//  3. Loopback into uart_rx (rst inverted to match its active-high reset), send 0x3C.
//     -> receive_ack pulses, data_i=0x3C, data_error=0.
//  4. CLKS_PER_BIT=4, send 0x80.
//     -> each bit held exactly 4 clks; frame is 44 clks; tx_ready low throughout
//        except the last STOP clk.
//  5. Reset mid-DATA (bit 3), then release.
//     -> txd=1 and tx_busy=0 immediately; the next byte 0x55 is sent as a clean
//        full frame.
//  6. PARITY_ODD=1, send 0x00.
//     -> parity bit = 1. tx_valid held while busy: exactly one frame per handshake.

Source files
------------

// File: rtl/uart_tx_pkg.sv
// uart_tx_pkg: shared one-hot state encoding, frame constants and parity helper
package uart_tx_pkg;

    localparam int DATA_BITS = 8;

    typedef enum logic [4:0] {
        S_IDLE   = 5'b00001,
        S_START  = 5'b00010,
        S_DATA   = 5'b00100,
        S_PARITY = 5'b01000,
        S_STOP   = 5'b10000
    } state_t;

    // Even parity is the XOR of the data bits; odd parity is its complement.
    function automatic logic parity_of(input logic [DATA_BITS-1:0] d, input logic odd);
        return (^d) ^ odd;
    endfunction

endpackage

// File: rtl/uart_tx_if.sv
// uart_tx_if: byte handshake and serial line bundle of the transmitter
interface uart_tx_if;

    logic [7:0] tx_data;
    logic       tx_valid;
    logic       tx_ready;
    logic       txd;
    logic       tx_busy;
    logic       tx_done;

    modport master (
        output tx_data, tx_valid,
        input  tx_ready, txd, tx_busy, tx_done
    );

    modport slave (
        input  tx_data, tx_valid,
        output tx_ready, txd, tx_busy, tx_done
    );

endinterface

// File: rtl/uart_baud_tick.sv
// uart_baud_tick: bit_end pulse every CLKS_PER_BIT clks while enabled
module uart_baud_tick #(
    parameter int CLKS_PER_BIT = 1
) (
    input  logic clk,
    input  logic rst_n,
    input  logic i_en,
    output logic o_bit_end
);

    localparam logic [15:0] LAST = 16'(CLKS_PER_BIT - 1);

    logic [15:0] r_bcnt;

    assign o_bit_end = i_en && (r_bcnt == LAST);

    // Count clks within a bit; restart at every bit boundary and hold at 0 when idle.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n)
            r_bcnt <= '0;
        else
            r_bcnt <= (!i_en || o_bit_end) ? '0 : r_bcnt + 16'd1;
    end

endmodule

// File: rtl/uart_tx.sv
// uart_tx: 11-bit frame serial transmitter (start, 8 data LSB-first, parity, stop)
module uart_tx
    import uart_tx_pkg::*;
#(
    parameter int CLKS_PER_BIT = 1,
    parameter int PARITY_ODD   = 0
) (
    input  logic      clk,
    input  logic      rst_n,
    uart_tx_if.slave  tx
);

    state_t      r_state;
    state_t      w_state_nxt;
    logic [2:0]  r_bit_cnt;
    logic [7:0]  r_shift;
    logic        r_parity;
    logic        r_txd;
    logic        w_txd_nxt;
    logic        w_bit_end;
    logic        w_ready;
    logic        w_xfer;

    uart_baud_tick #(.CLKS_PER_BIT(CLKS_PER_BIT)) u_baud (
        .clk       (clk),
        .rst_n     (rst_n),
        .i_en      (r_state != S_IDLE),
        .o_bit_end (w_bit_end)
    );

    // A new byte can be taken while idle or in the very last clk of the stop bit.
    assign w_ready     = (r_state == S_IDLE) || (r_state == S_STOP && w_bit_end);
    assign w_xfer      = tx.tx_valid && w_ready;
    assign tx.tx_ready = w_ready;
    assign tx.txd      = r_txd;
    assign tx.tx_busy  = r_state != S_IDLE;
    assign tx.tx_done  = (r_state == S_STOP) && w_bit_end;

    // Next state and the line level that the next state will drive.
    always_comb begin
        w_state_nxt = r_state;
        w_txd_nxt   = 1'b1;
        case (r_state)
            S_IDLE:   if (w_xfer) w_state_nxt = S_START;
            S_START:  if (w_bit_end) w_state_nxt = S_DATA;
            S_DATA:   if (w_bit_end && r_bit_cnt == 3'(DATA_BITS - 1)) w_state_nxt = S_PARITY;
            S_PARITY: if (w_bit_end) w_state_nxt = S_STOP;
            S_STOP:   if (w_bit_end) w_state_nxt = w_xfer ? S_START : S_IDLE;
            default:  w_state_nxt = S_IDLE;
        endcase
        case (w_state_nxt)
            S_START:  w_txd_nxt = 1'b0;
            S_DATA:   w_txd_nxt = (r_state == S_DATA && w_bit_end) ? r_shift[1] : r_shift[0];
            S_PARITY: w_txd_nxt = r_parity;
            default:  w_txd_nxt = 1'b1;
        endcase
    end

    // State, line register and bit counter; the counter restarts on every state change.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state   <= S_IDLE;
            r_txd     <= 1'b1;
            r_bit_cnt <= '0;
        end else begin
            r_state   <= w_state_nxt;
            r_txd     <= w_txd_nxt;
            r_bit_cnt <= (w_state_nxt != r_state) ? '0 :
                         (r_state == S_DATA && w_bit_end) ? r_bit_cnt + 3'd1 : r_bit_cnt;
        end
    end

    // Latch byte and parity on the handshake; shift right as each data bit completes.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_shift  <= '0;
            r_parity <= 1'b0;
        end else if (w_xfer) begin
            r_shift  <= tx.tx_data;
            r_parity <= parity_of(tx.tx_data, PARITY_ODD != 0);
        end else if (r_state == S_DATA && w_bit_end) begin
            r_shift  <= {1'b0, r_shift[7:1]};
        end
    end

endmodule
